hsi_ccw_buf: RTL

HSI_CCW_BUF -- requirements
Module: hsi_ccw_buf

---
 rtl/hsi_ccw_buf.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/hsi_ccw_buf.sv
// hsi_ccw_buf: message-oriented byte buffer between the host CCW writer and
// the TX controller. Bytes are collected into messages; a message becomes
// visible to the read side only once its final byte has been committed.
// Over-length messages and messages that hit a full buffer are dropped whole.
module hsi_ccw_buf #(
    parameter int DEPTH   = 64,
    parameter int MAX_MSG = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_d,
    input  logic                     wr_last,
    output logic                     full,
    output logic                     ccw_tx_rdy,
    output logic [7:0]               ccw_d,
    output logic                     ccw_last,
    input  logic                     ccw_tx_en,
    output logic [$clog2(DEPTH):0]   msg_cnt,
    output logic                     ovf,
    output logic                     err_len,
    output logic                     err_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_MSG + 1);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    // Storage: bit 8 is the end-of-message flag, bits 7:0 the data byte.
    logic [8:0]     r_mem [DEPTH];

    wr_state_t      r_state;
    wr_state_t      w_state_next;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_wr_tmp;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_msg_cnt;
    logic [CW-1:0]  r_byte_cnt;
    logic           r_ovf;
    logic           r_err_len;
    logic           r_err_rd;

    logic [PW-1:0]  w_wr_ptr_next;
    logic [PW-1:0]  w_wr_tmp_next;
    logic [PW-1:0]  w_wr_tmp_inc;
    logic [CW-1:0]  w_byte_cnt_next;
    logic           w_mem_we;
    logic           w_commit;
    logic           w_set_ovf;
    logic           w_set_err_len;
    logic           w_full;
    logic           w_tx_rdy;
    logic           w_pop;
    logic           w_pop_last;
    logic [8:0]     w_head;

    // Full counts uncommitted bytes as occupied, so it is measured from the
    // fill pointer rather than the committed write pointer.
    assign w_full       = ((r_wr_tmp - r_rd_ptr) == PW'(DEPTH));
    assign w_tx_rdy     = (r_msg_cnt != '0);
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop        = ccw_tx_en & w_tx_rdy;
    assign w_pop_last   = w_pop & w_head[8];
    assign w_wr_tmp_inc = r_wr_tmp + PW'(1);

    assign full       = w_full;
    assign ccw_tx_rdy = w_tx_rdy;
    assign ccw_d      = w_head[7:0];
    assign ccw_last   = w_head[8];
    assign msg_cnt    = r_msg_cnt;
    assign ovf        = r_ovf;
    assign err_len    = r_err_len;
    assign err_rd     = r_err_rd;

    // Write FSM: accept, commit or drop the incoming byte.
    always_comb begin
        w_state_next    = r_state;
        w_wr_ptr_next   = r_wr_ptr;
        w_wr_tmp_next   = r_wr_tmp;
        w_byte_cnt_next = r_byte_cnt;
        w_mem_we        = 1'b0;
        w_commit        = 1'b0;
        w_set_ovf       = 1'b0;
        w_set_err_len   = 1'b0;
        if (wr_en) begin
            case (r_state)
                WR_IDLE, WR_FILL: begin
                    if (w_full) begin
                        // No room: abandon the partial message entirely.
                        w_wr_tmp_next   = r_wr_ptr;
                        w_byte_cnt_next = '0;
                        w_set_ovf       = 1'b1;
                        w_state_next    = wr_last ? WR_IDLE : WR_DROP;
                    end else if (r_byte_cnt == CW'(MAX_MSG)) begin
                        // This byte would exceed the per-message limit.
                        w_wr_tmp_next   = r_wr_ptr;
                        w_byte_cnt_next = '0;
                        w_set_err_len   = 1'b1;
                        w_state_next    = wr_last ? WR_IDLE : WR_DROP;
                    end else begin
                        w_mem_we      = 1'b1;
                        w_wr_tmp_next = w_wr_tmp_inc;
                        if (wr_last) begin
                            w_commit        = 1'b1;
                            w_wr_ptr_next   = w_wr_tmp_inc;
                            w_byte_cnt_next = '0;
                            w_state_next    = WR_IDLE;
                        end else begin
                            w_byte_cnt_next = r_byte_cnt + CW'(1);
                            w_state_next    = WR_FILL;
                        end
                    end
                end
                WR_DROP: begin
                    if (wr_last) begin
                        w_state_next = WR_IDLE;
                    end
                end
                default: begin
                    w_state_next = WR_IDLE;
                end
            endcase
        end
    end

    // Data array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we && !flush) begin
            r_mem[r_wr_tmp[AW-1:0]] <= {wr_last, wr_d};
        end
    end

    // Control state: pointers, message count, FSM and sticky error flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= WR_IDLE;
            r_wr_ptr   <= '0;
            r_wr_tmp   <= '0;
            r_rd_ptr   <= '0;
            r_msg_cnt  <= '0;
            r_byte_cnt <= '0;
            r_ovf      <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_rd   <= 1'b0;
        end else if (flush) begin
            r_state    <= WR_IDLE;
            r_wr_ptr   <= '0;
            r_wr_tmp   <= '0;
            r_rd_ptr   <= '0;
            r_msg_cnt  <= '0;
            r_byte_cnt <= '0;
            r_ovf      <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_rd   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_wr_tmp   <= w_wr_tmp_next;
            r_byte_cnt <= w_byte_cnt_next;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // A commit and a final-byte pop together cancel out.
            case ({w_commit, w_pop_last})
                2'b10:   r_msg_cnt <= r_msg_cnt + PW'(1);
                2'b01:   r_msg_cnt <= r_msg_cnt - PW'(1);
                default: r_msg_cnt <= r_msg_cnt;
            endcase
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_set_err_len) begin
                r_err_len <= 1'b1;
            end
            if (ccw_tx_en && !w_tx_rdy) begin
                r_err_rd <= 1'b1;
            end
        end
    end

endmodule
